temp_bcd_source: RTL and testbench
==================================

Name: temp_bcd_source

Overview:
- Producer side of the BCD temperature bus consumed by the alarm/ventilation logic.
- Accepts 8-bit binary Celsius samples from the ADC front end for two channels, ambient and body, using a valid/ready handshake.
- Saturates each sample, then converts it to two-digit packed BCD with a sequential double-dabble engine.
- Holds the latest value per channel on temp_amb / temp_corp: upper nibble = tens, lower nibble = units.

Parameters:
- SAT_MAX, 8'd99, binary clamp ceiling applied before conversion; legal range 0..99.
- RST_AMB, 8'h00, packed-BCD reset value of temp_amb.
- RST_CORP, 8'h00, packed-BCD reset value of temp_corp.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- sample_valid  input  1  sample_data/sample_ch are valid
- sample_ready  output  1  block can accept a sample
- sample_ch  input  1  0 = ambient, 1 = body
- sample_data  input  8  unsigned binary temperature, degrees C
- temp_amb  output  8  packed BCD ambient temperature
- temp_corp  output  8  packed BCD body temperature
- upd_amb  output  1  one-cycle pulse when temp_amb is rewritten
- upd_corp  output  1  one-cycle pulse when temp_corp is rewritten
- busy  output  1  conversion in progress (equals ~sample_ready)
- sat  output  1  last accepted sample was clamped

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - temp_amb = RST_AMB, temp_corp = RST_CORP.
  - upd_amb = upd_corp = 0, sat = 0, busy = 0, sample_ready = 1.
  - FSM = IDLE; shift register and iteration counter cleared.
- FSM has three states: IDLE, CONV, LOAD.
- IDLE:
  - sample_ready = 1.
  - Transfer occurs at the edge where sample_valid & sample_ready = 1.
  - At that edge: latch channel; latch v = min(sample_data, SAT_MAX); set sat = (sample_data > SAT_MAX); clear BCD scratch; counter = 0; go to CONV.
  - sample_data/sample_ch are not sampled in any other state.
- CONV:
  - sample_ready = 0.
  - One double-dabble iteration per cycle: add 3 to each BCD nibble >= 5, then shift left one bit taking the MSB of v.
  - Exactly 8 iterations; counter 0..7, leaving when counter = 7.
  - The scratch needs only 8 BCD bits, since SAT_MAX <= 99.
- LOAD:
  - sample_ready = 0.
  - Write the scratch to temp_amb (ch = 0) or temp_corp (ch = 1).
  - Assert the matching upd_* for exactly the next cycle; return to IDLE.
- Latency:
  - Transfer at edge k → new value and upd_* visible after edge k+9.
  - Throughput is one sample per 10 cycles.
  - Back-to-back: with valid held high, the next transfer occurs at edge k+10.
- Output stability: temp_amb and temp_corp change only at a LOAD edge or on reset. The non-selected channel is never disturbed.
- sat holds its value until the next transfer.
- upd_amb and upd_corp are never high in the same cycle.
- Boundaries:
  - sample_data = 0 → 8'h00.
  - sample_data = SAT_MAX → BCD(SAT_MAX), sat = 0.
  - sample_data = 255 → BCD(SAT_MAX), sat = 1.
- Reset mid-CONV or mid-LOAD: the conversion is aborted, no upd_* pulse is produced, and both temp registers take their reset values.
- sample_valid asserted while busy: ignored. The source must hold data until ready; no data loss or duplication is allowed.

Optional Feature:
- Macro: TEMP_AVG4_EN.
- When defined:
  - Each channel keeps a 4-entry history of raw samples.
  - On transfer, the new sample shifts in; v = min((sum of 4 entries) >> 2, SAT_MAX), truncating division.
  - sat reflects the averaged value exceeding SAT_MAX.
  - The first transfer per channel after reset fills all 4 entries with that sample.
  - Averaging is done in the transfer cycle; latency is unchanged.
  - Reset clears the history and the per-channel "filled" flags.
- When undefined: no history storage; v comes directly from sample_data as described above.

Test Plan:
- Reset, then ch = 0, data = 25 → after 9 edges temp_amb = 8'h25 and upd_amb pulses 1 cycle; temp_corp stays 8'h00; sat = 0.
- ch = 1 with data = 37, then 99, then 0 → temp_corp = 8'h37, 8'h99, 8'h00 in turn; one upd_corp pulse each; sample_ready low for exactly 9 cycles after each transfer.
- ch = 1, data = 150, and separately data = 255 → temp_corp = 8'h99, sat = 1. Next, data = 38 → 8'h38, sat = 0.
- Hold valid with ch = 0 data = 30, then ch = 0 data = 31 presented while busy → second transfer at edge k+10; temp_amb goes 8'h30 then 8'h31; exactly two upd_amb pulses.
- Transfer ch = 0 data = 42, assert reset at edge k+4 → no upd_amb; temp_amb = RST_AMB; sample_ready = 1 the cycle after reset releases.
- With TEMP_AVG4_EN: ch = 1 samples 36, 36, 40, 40 → temp_corp = 8'h36, 8'h36, 8'h37, 8'h38.

Source files
------------

// File: rtl/temp_bcd_source.sv
// Two-channel binary-to-BCD temperature source: saturate, double-dabble, hold per channel.
// Optional TEMP_AVG4_EN macro enables a 4-sample moving average per channel.
module temp_bcd_source #(
   parameter logic [7:0] SAT_MAX  = 8'd99,
   parameter logic [7:0] RST_AMB  = 8'h00,
   parameter logic [7:0] RST_CORP = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_valid,
   output logic       sample_ready,
   input  logic       sample_ch,
   input  logic [7:0] sample_data,
   output logic [7:0] temp_amb,
   output logic [7:0] temp_corp,
   output logic       upd_amb,
   output logic       upd_corp,
   output logic       busy,
   output logic       sat
);

   typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

   state_e     state;
   logic       ch;
   logic [7:0] bin;
   logic [7:0] bcd;
   logic [2:0] cnt;

   logic       xfer;
   logic [7:0] avg;
   logic       clamp_sat;
   logic [7:0] clamp_v;
   logic [2:0] tens_adj;
   logic [3:0] units_adj;

   assign sample_ready = (state == StIdle);
   assign busy         = ~sample_ready;
   assign xfer         = sample_valid & sample_ready;

`ifdef TEMP_AVG4_EN
   // Only the three previous samples are stored; the fourth window entry is the incoming one.
   logic [7:0] hist [2][3];
   logic [1:0] filled;
   logic [9:0] sum;

   always_comb begin
      if (filled[sample_ch]) begin
         sum = {2'b00, sample_data} + {2'b00, hist[sample_ch][0]} +
               {2'b00, hist[sample_ch][1]} + {2'b00, hist[sample_ch][2]};
      end else begin
         sum = {sample_data, 2'b00};
      end
      avg = 8'(sum >> 2);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         filled <= 2'b00;
         for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 3; i++) begin
               hist[c][i] <= 8'h00;
            end
         end
      end else if (xfer) begin
         filled[sample_ch] <= 1'b1;
         if (filled[sample_ch]) begin
            hist[sample_ch][0] <= sample_data;
            hist[sample_ch][1] <= hist[sample_ch][0];
            hist[sample_ch][2] <= hist[sample_ch][1];
         end else begin
            for (int i = 0; i < 3; i++) begin
               hist[sample_ch][i] <= sample_data;
            end
         end
      end
   end
`else
   assign avg = sample_data;
`endif

   assign clamp_sat = (avg > SAT_MAX);
   assign clamp_v   = clamp_sat ? SAT_MAX : avg;

   // Tens digit never exceeds 9, so the adjusted tens bit 3 is always shifted out.
   assign tens_adj  = (bcd[7:4] >= 4'd5) ? bcd[6:4] + 3'd3 : bcd[6:4];
   assign units_adj = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         ch        <= 1'b0;
         bin       <= 8'h00;
         bcd       <= 8'h00;
         cnt       <= 3'd0;
         temp_amb  <= RST_AMB;
         temp_corp <= RST_CORP;
         upd_amb   <= 1'b0;
         upd_corp  <= 1'b0;
         sat       <= 1'b0;
      end else begin
         upd_amb  <= 1'b0;
         upd_corp <= 1'b0;
         unique case (state)
            StIdle: begin
               if (xfer) begin
                  ch    <= sample_ch;
                  bin   <= clamp_v;
                  sat   <= clamp_sat;
                  bcd   <= 8'h00;
                  cnt   <= 3'd0;
                  state <= StConv;
               end
            end
            StConv: begin
               bcd <= {tens_adj, units_adj, bin[7]};
               bin <= {bin[6:0], 1'b0};
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  state <= StLoad;
               end
            end
            StLoad: begin
               if (ch) begin
                  temp_corp <= bcd;
                  upd_corp  <= 1'b1;
               end else begin
                  temp_amb <= bcd;
                  upd_amb  <= 1'b1;
               end
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_temp_bcd_source.sv
// Self-checking bench for temp_bcd_source: directed and random samples against a decimal model.
module tb_temp_bcd_source;

   localparam int SatMax = 99;

   logic       clk = 1'b0;
   logic       reset;
   logic       sample_valid;
   logic       sample_ready;
   logic       sample_ch;
   logic [7:0] sample_data;
   logic [7:0] temp_amb;
   logic [7:0] temp_corp;
   logic       upd_amb;
   logic       upd_corp;
   logic       busy;
   logic       sat;

   int n_checks = 0;
   int n_errors = 0;
   int n_upd_amb = 0;
   int n_upd_corp = 0;
   int n_both = 0;
   int exp_upd_amb = 0;
   int exp_upd_corp = 0;

   // Reference model state
   int         hist_m [2][4];
   bit         filled_m [2];
   logic [7:0] exp_amb;
   logic [7:0] exp_corp;
   bit         exp_sat;

   temp_bcd_source dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_ch    (sample_ch),
      .sample_data  (sample_data),
      .temp_amb     (temp_amb),
      .temp_corp    (temp_corp),
      .upd_amb      (upd_amb),
      .upd_corp     (upd_corp),
      .busy         (busy),
      .sat          (sat)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (upd_amb) n_upd_amb++;
      if (upd_corp) n_upd_corp++;
      if (upd_amb && upd_corp) n_both++;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_amb  = 8'h00;
      exp_corp = 8'h00;
      exp_sat  = 1'b0;
      for (int c = 0; c < 2; c++) begin
         filled_m[c] = 1'b0;
         for (int i = 0; i < 4; i++) hist_m[c][i] = 0;
      end
   endtask

   task automatic model_xfer(input bit ch, input int d);
      int v;
      logic [7:0] b;
`ifdef TEMP_AVG4_EN
      if (!filled_m[ch]) begin
         for (int i = 0; i < 4; i++) hist_m[ch][i] = d;
         filled_m[ch] = 1'b1;
      end else begin
         for (int i = 3; i > 0; i--) hist_m[ch][i] = hist_m[ch][i-1];
         hist_m[ch][0] = d;
      end
      v = (hist_m[ch][0] + hist_m[ch][1] + hist_m[ch][2] + hist_m[ch][3]) / 4;
`else
      v = d;
`endif
      exp_sat = (v > SatMax);
      if (exp_sat) v = SatMax;
      b = 8'(((v / 10) * 16) + (v % 10));
      if (ch) begin
         exp_corp = b;
         exp_upd_corp++;
      end else begin
         exp_amb = b;
         exp_upd_amb++;
      end
   endtask

   // Called at a negedge; returns at the negedge after the result edge (k+9).
   task automatic xfer(input bit ch, input logic [7:0] d,
                       input bit nv, input bit nch, input logic [7:0] nd);
      int w;
      sample_valid = 1'b1;
      sample_ch    = ch;
      sample_data  = d;
      w = 0;
      while (!sample_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait", 32'(sample_ready), 32'd1);
      @(posedge clk);
      model_xfer(ch, int'(d));
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check("busy_ready", 32'({sample_ready, busy}), 32'b01);
         check("busy_upd", 32'({upd_amb, upd_corp}), 32'b00);
         if (nv) begin
            sample_valid = 1'b1;
            sample_ch    = nch;
            sample_data  = nd;
         end else begin
            sample_valid = 1'($urandom_range(0, 1));
            sample_ch    = 1'($urandom_range(0, 1));
            sample_data  = 8'($urandom_range(0, 255));
         end
      end
      @(negedge clk);
      check("done_ready", 32'(sample_ready), 32'd1);
      check("temp_amb", 32'(temp_amb), 32'(exp_amb));
      check("temp_corp", 32'(temp_corp), 32'(exp_corp));
      check("sat", 32'(sat), 32'(exp_sat));
      check("upd_pulse", 32'({upd_amb, upd_corp}), ch ? 32'b01 : 32'b10);
      sample_valid = nv;
      sample_ch    = nch;
      sample_data  = nd;
   endtask

   initial begin
      logic [7:0] d;
      int r;
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_ch    = 1'b0;
      sample_data  = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_temps", 32'({temp_amb, temp_corp}), 32'h0000);
      check("rst_flags", 32'({upd_amb, upd_corp, sat, busy, sample_ready}), 32'b00001);
      reset = 1'b0;
      @(negedge clk);

      xfer(1'b0, 8'd25, 1'b0, 1'b0, 8'd0);
      xfer(1'b1, 8'd37, 1'b0, 1'b0, 8'd0);
      xfer(1'b1, 8'd99, 1'b0, 1'b0, 8'd0);
      xfer(1'b1, 8'd0, 1'b0, 1'b0, 8'd0);
      xfer(1'b1, 8'd150, 1'b0, 1'b0, 8'd0);
      xfer(1'b1, 8'd255, 1'b0, 1'b0, 8'd0);
      xfer(1'b1, 8'd38, 1'b0, 1'b0, 8'd0);
      // Back-to-back: next sample presented while busy, valid held high
      xfer(1'b0, 8'd30, 1'b1, 1'b0, 8'd31);
      xfer(1'b0, 8'd31, 1'b0, 1'b0, 8'd0);

      // Abort a conversion with reset at edge k+4
      sample_valid = 1'b1;
      sample_ch    = 1'b0;
      sample_data  = 8'd42;
      @(posedge clk);
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      model_reset();
      check("abort_temps", 32'({temp_amb, temp_corp}), 32'({exp_amb, exp_corp}));
      check("abort_flags", 32'({upd_amb, upd_corp, sat, sample_ready}), 32'b0001);
      reset = 1'b0;
      @(negedge clk);
      check("abort_ready", 32'({sample_ready, upd_amb}), 32'b10);

      xfer(1'b1, 8'd36, 1'b0, 1'b0, 8'd0);
      xfer(1'b1, 8'd36, 1'b0, 1'b0, 8'd0);
      xfer(1'b1, 8'd40, 1'b0, 1'b0, 8'd0);
      xfer(1'b1, 8'd40, 1'b0, 1'b0, 8'd0);

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0: d = 8'd0;
            1: d = 8'd99;
            2: d = 8'd100;
            3: d = 8'd255;
            default: d = 8'($urandom_range(0, 255));
         endcase
         xfer(1'($urandom_range(0, 1)), d, 1'b0, 1'b0, 8'd0);
      end

      repeat (3) @(negedge clk);
      check("upd_amb_count", 32'(n_upd_amb), 32'(exp_upd_amb));
      check("upd_corp_count", 32'(n_upd_corp), 32'(exp_upd_corp));
      check("upd_both", 32'(n_both), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
